player_motion: RTL and testbench
================================

PLAYER_MOTION -- requirements
Module: player_motion

Interface
REQ-001 SHALL have parameters, one per line:
  SCREEN_W 800: screen width in pixels
  SPR_W 22: sprite width
  SPR_H 24: sprite height
  FLOOR_Y 552: sprite top row when standing
  START_X 100: reset x
  WALK_SPEED 3: pixels per frame
  JUMP_V 8: first-jump speed
  JUMP2_V 6: second-jump speed
  MAX_FALL 9: fall-speed cap
REQ-002 SHALL have ports, one per line:
  clk  in  1  system clock; the only clock
  clrn  in  1  asynchronous active-low reset
  vsync  in  1  VGA vsync, active-low pulse, asynchronous to clk
  left  in  1  move-left button level, asynchronous
  right  in  1  move-right button level, asynchronous
  jump  in  1  jump button level, asynchronous
  pos_x  out  10  sprite left column, consumed by render
  pos_y  out  10  sprite top row, consumed by render
  facing  out  1  0 = right, 1 = left
  airborne  out  1  1 while not standing
  update_done  out  1  one-cycle pulse on each frame update

Function
REQ-003 SHALL synchronise vsync, left, right and jump through two flops each; only synchronised copies are used.
REQ-004 SHALL raise an internal frame_tick for one clk when synchronised vsync goes 1->0.
REQ-005 SHALL apply the frame update, and pulse update_done, on the clk edge where frame_tick is high; outputs SHALL be stable between updates.
REQ-006 SHALL set a jump_req latch on each synchronised jump 0->1 edge; frame_tick SHALL consume and clear it; an edge in the same cycle as frame_tick SHALL be serviced in that frame.
REQ-007 SHALL keep signed 6-bit vertical velocity vy, positive = downward.
REQ-008 SHALL keep jumps_left in 0..2.
REQ-009 SHALL use states GROUND, RISE (vy<0) and FALL (vy>=0, airborne); airborne = state != GROUND.
REQ-010 Horizontal, per update:
  - left only: pos_x -= WALK_SPEED, floored at 0; facing = 1.
  - right only: pos_x += WALK_SPEED, capped at SCREEN_W-SPR_W = 778; facing = 0.
  - neither or both: pos_x and facing unchanged.
REQ-011 Vertical, per update, in this order:
  - (a) jump_req: GROUND -> vy = -JUMP_V, jumps_left = 1; airborne with jumps_left = 1 -> vy = -JUMP2_V, jumps_left = 0; otherwise dropped.
  - (b) synchronised jump low and vy < -2 in RISE -> vy = -2 (release cut).
  - (c) pos_y += vy.
  - (d) vy = min(vy + 1, MAX_FALL).
REQ-012 In GROUND with no jump, pos_y and vy SHALL remain FLOOR_Y and 0.
REQ-013 Landing: if airborne and pos_y + vy >= FLOOR_Y at step (c), then pos_y = FLOOR_Y, vy = 0, state = GROUND, jumps_left = 2, and step (d) is skipped.
REQ-014 Ceiling: if pos_y + vy < 0 at step (c), then pos_y = 0, vy = 0, state = FALL.
REQ-015 All position arithmetic SHALL be done in 11-bit signed width before clamping; pos_x and pos_y SHALL never leave 0..778 and 0..FLOOR_Y.

Reset
REQ-016 On clrn low, asynchronously:
  - pos_x = START_X = 100, pos_y = FLOOR_Y = 552
  - vy = 0, state = GROUND, jumps_left = 2
  - facing = 0, airborne = 0, update_done = 0
  - jump_req and all synchroniser flops cleared
REQ-017 Reset mid-jump SHALL abandon the jump; the first update after release SHALL start from the reset values.

Verification
REQ-018 Reset, then 3 frames with no buttons -> pos = (100,552), airborne = 0, update_done pulses once per vsync fall.
REQ-019 right held 10 frames -> pos_x = 130, facing = 0; right held 300 frames -> pos_x = 778, no wrap; left and right both held -> pos_x unchanged.
REQ-020 jump pressed and held from ground:
  - frame 1: pos_y = 544, vy = -7.
  - frame 9: peak pos_y = 516.
  - frame 17: pos_y = 552, airborne = 0.
REQ-021 jump tapped, released before frame 2 -> release cut gives vy = -2 at frame 2; second tap while airborne -> vy = -6; third tap ignored with jumps_left = 0.
REQ-022 jump edge in the same cycle as frame_tick -> jump serviced in that update; clrn pulsed mid-jump -> pos = (100,552), airborne = 0 immediately.

Source files
------------

// File: rtl/player_motion.sv
// player_motion -- per-frame sprite motion for a platformer character.
//
// Samples the (asynchronous) buttons once per video frame, on the falling
// edge of vsync, and advances the sprite: horizontal walk with screen-edge
// clamping, and a vertical jump/double-jump model with gravity, a release
// cut for short hops, a floor and a ceiling.
//
// Ports
//   clk          system clock (the only clock)
//   clrn         asynchronous active-low reset
//   vsync        VGA vsync, active-low pulse, asynchronous
//   left/right   walk button levels, asynchronous
//   jump         jump button level, asynchronous
//   pos_x/pos_y  sprite top-left corner for the renderer
//   facing       0 = right, 1 = left
//   airborne     1 while not standing on the floor
//   update_done  one-cycle pulse after each frame update
module player_motion #(
  parameter int SCREEN_W   = 800,
  parameter int SPR_W      = 22,
  parameter int SPR_H      = 24,
  parameter int FLOOR_Y    = 552,
  parameter int START_X    = 100,
  parameter int WALK_SPEED = 3,
  parameter int JUMP_V     = 8,
  parameter int JUMP2_V    = 6,
  parameter int MAX_FALL   = 9
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       vsync,
  input  logic       left,
  input  logic       right,
  input  logic       jump,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       facing,
  output logic       airborne,
  output logic       update_done
);

  // Sprite must fit in the 10-bit coordinate space of the renderer.
  if ((FLOOR_Y + SPR_H) > 1024 || SCREEN_W > 1024) begin : g_bad_geometry
    $error("player_motion: geometry does not fit 10-bit coordinates");
  end

  typedef enum logic [1:0] {GROUND, RISE, FALL} state_t;

  localparam logic signed [10:0] X_MAX   = 11'(SCREEN_W - SPR_W);
  localparam logic signed [10:0] FLOOR_S = 11'(FLOOR_Y);
  localparam logic signed [10:0] WALK_S  = 11'(WALK_SPEED);
  localparam logic signed [5:0]  JV1     = 6'(-JUMP_V);
  localparam logic signed [5:0]  JV2     = 6'(-JUMP2_V);
  localparam logic signed [5:0]  VMAX    = 6'(MAX_FALL);
  localparam logic signed [5:0]  VCUT    = -6'sd2;

  // Two-flop synchronisers plus one history flop for edge detection.
  logic [1:0] vs_q, lf_q, rt_q, jp_q;
  logic       vs_prev_q, jp_prev_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      vs_q      <= '0;
      lf_q      <= '0;
      rt_q      <= '0;
      jp_q      <= '0;
      vs_prev_q <= 1'b0;
      jp_prev_q <= 1'b0;
    end else begin
      vs_q      <= {vs_q[0], vsync};
      lf_q      <= {lf_q[0], left};
      rt_q      <= {rt_q[0], right};
      jp_q      <= {jp_q[0], jump};
      vs_prev_q <= vs_q[1];
      jp_prev_q <= jp_q[1];
    end
  end

  logic left_s, right_s, jump_s, frame_tick, jump_edge;
  assign left_s     = lf_q[1];
  assign right_s    = rt_q[1];
  assign jump_s     = jp_q[1];
  assign frame_tick = vs_prev_q & ~vs_q[1];
  assign jump_edge  = jump_s & ~jp_prev_q;

  // Motion state
  state_t            state_q, state_d;
  logic [9:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [5:0] vy_q, vy_d;
  logic [1:0]        jl_q, jl_d;
  logic              facing_q, facing_d, jump_req_q, jump_req_d;
  logic              update_done_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q       <= GROUND;
      pos_x_q       <= 10'(START_X);
      pos_y_q       <= 10'(FLOOR_Y);
      vy_q          <= '0;
      jl_q          <= 2'd2;
      facing_q      <= 1'b0;
      jump_req_q    <= 1'b0;
      update_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      vy_q          <= vy_d;
      jl_q          <= jl_d;
      facing_q      <= facing_d;
      jump_req_q    <= jump_req_d;
      update_done_q <= frame_tick;
    end
  end

  logic signed [10:0] x_s, y_s;
  logic signed [5:0]  vy_t, vy_n;
  logic [1:0]         jl_t;
  logic               air_t;

  always_comb begin
    state_d    = state_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    vy_d       = vy_q;
    jl_d       = jl_q;
    facing_d   = facing_q;
    // An edge arriving with the tick is serviced by this tick, not latched.
    jump_req_d = jump_req_q | jump_edge;
    x_s        = '0;
    y_s        = '0;
    vy_t       = vy_q;
    vy_n       = '0;
    jl_t       = jl_q;
    air_t      = (state_q != GROUND);

    if (frame_tick) begin
      jump_req_d = 1'b0;

      // Horizontal: simultaneous left+right cancel out.
      if (left_s && !right_s) begin
        x_s = $signed({1'b0, pos_x_q}) - WALK_S;
        if (x_s < 11'sd0) x_s = 11'sd0;
        pos_x_d  = x_s[9:0];
        facing_d = 1'b1;
      end else if (right_s && !left_s) begin
        x_s = $signed({1'b0, pos_x_q}) + WALK_S;
        if (x_s > X_MAX) x_s = X_MAX;
        pos_x_d  = x_s[9:0];
        facing_d = 1'b0;
      end

      // Jump request: first jump from the floor, one extra in the air.
      if (jump_req_q || jump_edge) begin
        if (!air_t) begin
          vy_t  = JV1;
          jl_t  = 2'd1;
          air_t = 1'b1;
        end else if (jl_t == 2'd1) begin
          vy_t = JV2;
          jl_t = 2'd0;
        end
      end

      // Releasing the button while rising shortens the jump.
      if (!jump_s && state_q == RISE && vy_t < VCUT) vy_t = VCUT;

      // Standing still on the floor leaves pos_y/vy untouched.
      if (air_t) begin
        y_s = $signed({1'b0, pos_y_q}) + {{5{vy_t[5]}}, vy_t};
        jl_d = jl_t;
        if (y_s >= FLOOR_S) begin
          pos_y_d = 10'(FLOOR_Y);
          vy_d    = '0;
          state_d = GROUND;
          jl_d    = 2'd2;
        end else if (y_s < 11'sd0) begin
          pos_y_d = '0;
          vy_d    = '0;
          state_d = FALL;
        end else begin
          pos_y_d = y_s[9:0];
          vy_n    = vy_t + 6'sd1;
          if (vy_n > VMAX) vy_n = VMAX;
          vy_d    = vy_n;
          state_d = (vy_n < 6'sd0) ? RISE : FALL;
        end
      end
    end
  end

  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign facing      = facing_q;
  assign airborne    = (state_q != GROUND);
  assign update_done = update_done_q;

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion: walk clamping, jump arc, release cut,
// double jump, same-cycle jump/frame, and asynchronous reset mid-jump.
module tb_player_motion;
  logic       clk = 1'b0;
  logic       clrn, vsync, left, right, jump;
  logic [9:0] pos_x, pos_y;
  logic       facing, airborne, update_done;

  int n_chk = 0;
  int n_err = 0;

  player_motion dut (
    .clk(clk), .clrn(clrn), .vsync(vsync), .left(left), .right(right),
    .jump(jump), .pos_x(pos_x), .pos_y(pos_y), .facing(facing),
    .airborne(airborne), .update_done(update_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // n vsync pulses; each must produce exactly one update_done pulse.
  task automatic frames(input int n);
    int pulses;
    pulses = 0;
    for (int f = 0; f < n; f++) begin
      vsync = 1'b0;
      repeat (8) begin @(negedge clk); if (update_done) pulses++; end
      vsync = 1'b1;
      repeat (4) begin @(negedge clk); if (update_done) pulses++; end
    end
    check("update_done pulses", pulses, n);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pos(input string tag, input int x, input int y, input int air);
    check({tag, " x"}, int'(pos_x), x);
    check({tag, " y"}, int'(pos_y), y);
    check({tag, " airborne"}, int'(airborne), air);
  endtask

  initial begin
    clrn = 1'b0; vsync = 1'b1; left = 1'b0; right = 1'b0; jump = 1'b0;
    idle(3);
    pos("reset", 100, 552, 0);
    check("reset facing", int'(facing), 0);
    check("reset update_done", int'(update_done), 0);
    clrn = 1'b1;
    idle(6);
    check("no spurious update", int'(update_done), 0);

    // Idle frames
    frames(3);
    pos("idle 3 frames", 100, 552, 0);

    // Walking and clamps
    right = 1'b1; frames(10);
    pos("right x10", 130, 552, 0);
    check("right facing", int'(facing), 0);
    left = 1'b1; frames(5);
    check("both held x", int'(pos_x), 130);
    check("both held facing", int'(facing), 0);
    right = 1'b0; frames(1);
    check("left x1", int'(pos_x), 127);
    check("left facing", int'(facing), 1);
    right = 1'b1; frames(2);
    check("both keep facing", int'(facing), 1);
    left = 1'b0; frames(216);
    check("right near edge", int'(pos_x), 775);
    frames(1);
    check("right at edge", int'(pos_x), 778);
    frames(83);
    check("right no wrap", int'(pos_x), 778);
    check("right edge facing", int'(facing), 0);
    right = 1'b0; left = 1'b1; frames(259);
    check("left near 0", int'(pos_x), 1);
    frames(1);
    check("left floored", int'(pos_x), 0);
    frames(2);
    check("left stays 0", int'(pos_x), 0);
    check("left edge facing", int'(facing), 1);
    left = 1'b0;

    // Held jump: full arc
    jump = 1'b1; idle(4);
    frames(1);
    pos("jump f1", 0, 544, 1);
    frames(8);
    check("jump f9 peak", int'(pos_y), 516);
    frames(7);
    pos("jump f16", 0, 544, 1);
    frames(1);
    pos("jump f17 land", 0, 552, 0);
    jump = 1'b0; idle(4);

    // Tap, release cut, double jump, ignored third tap
    jump = 1'b1; idle(4); jump = 1'b0; idle(4);
    frames(1);
    pos("tap f1", 0, 544, 1);
    frames(1);
    check("tap f2 cut", int'(pos_y), 542);
    frames(1);
    check("tap f3", int'(pos_y), 541);
    jump = 1'b1; idle(4);
    frames(1);
    check("double jump", int'(pos_y), 535);
    jump = 1'b0; idle(4);
    frames(1);
    check("double cut", int'(pos_y), 533);
    jump = 1'b1; idle(4);
    frames(1);
    check("third tap ignored", int'(pos_y), 532);
    jump = 1'b0; idle(4);
    frames(6);
    pos("fall f12", 0, 547, 1);
    frames(1);
    pos("tap land", 0, 552, 0);

    // Jumps restored after landing
    jump = 1'b1; idle(4); jump = 1'b0; idle(4);
    frames(1);
    pos("rejump f1", 0, 544, 1);
    frames(8);
    pos("rejump land", 0, 552, 0);

    // Jump edge in the same cycle as the frame tick
    jump = 1'b1;
    frames(1);
    pos("same-cycle jump", 0, 544, 1);
    frames(1);
    check("no stale jump_req", int'(pos_y), 537);

    // Asynchronous reset mid-jump
    jump = 1'b0;
    #3 clrn = 1'b0;
    #1;
    pos("async reset", 100, 552, 0);
    check("async reset facing", int'(facing), 0);
    @(negedge clk); clrn = 1'b1;
    idle(4);
    frames(1);
    pos("after reset frame", 100, 552, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
